// File: rtl/fifo_scoreboard_chk.sv
// Cycle-accurate FIFO scoreboard: shadows the DUT FIFO from snooped write/read traffic,
// checks popped data and full/empty flags, and produces a pass/fail verdict at end of test.
module fifo_scoreboard_chk #(
   parameter int DW         = 8,
   parameter int DEPTH      = 16,
   parameter int RD_LATENCY = 1,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             wr_en,
   input  logic [DW-1:0]    wr_data,
   input  logic             rd_en,
   input  logic [DW-1:0]    rd_data,
   input  logic             full,
   input  logic             empty,
   input  logic             test_done,
   output logic [CNT_W-1:0] match_cnt,
   output logic [CNT_W-1:0] mismatch_cnt,
   output logic [CNT_W-1:0] flag_err_cnt,
   output logic             error,
   output logic             done,
   output logic             pass
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_FLUSH = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;
   localparam logic [AW:0]      OCC_FULL = (AW+1)'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   // Statistics counters stick at all-ones instead of wrapping back to a misleading small value.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
      if (en && (v != CNT_MAX)) begin
         return v + CNT_W'(1);
      end else begin
         return v;
      end
   endfunction

   logic [1:0]       state_r;
   logic [AW:0]      occ_r;
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [DW-1:0]    mem_r [DEPTH];
   logic             pend_vld_r;
   logic [DW-1:0]    pend_data_r;
   logic [CNT_W-1:0] match_cnt_r;
   logic [CNT_W-1:0] mismatch_cnt_r;
   logic [CNT_W-1:0] flag_err_cnt_r;
   logic             error_r;
   logic             done_r;
   logic             pass_r;

   logic [1:0]       state_s;
   logic             run_s;
   logic             wr_acc_s;
   logic             rd_acc_s;
   logic             flag_bad_s;
   logic             cmp_vld_s;
   logic [DW-1:0]    cmp_exp_s;
   logic             cmp_ok_s;
   logic             cmp_bad_s;
   logic [AW:0]      occ_s;
   logic [CNT_W-1:0] match_s;
   logic             error_s;
   logic             pass_s;

   // Next-state, acceptance, compare and verdict decisions for the current cycle.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE:  state_s = ST_RUN;
         ST_RUN: begin
            if (test_done) begin
               state_s = (RD_LATENCY == 0) ? ST_DONE : ST_FLUSH;
            end else begin
               state_s = ST_RUN;
            end
         end
         ST_FLUSH: state_s = ST_DONE;
         ST_DONE:  state_s = ST_DONE;
         default:  state_s = ST_IDLE;
      endcase

      run_s      = (state_r == ST_RUN);
      wr_acc_s   = run_s && wr_en && (occ_r != OCC_FULL);
      rd_acc_s   = run_s && rd_en && (occ_r != '0);
      flag_bad_s = run_s && ((empty != (occ_r == '0)) || (full != (occ_r == OCC_FULL)));

      // Zero latency compares the word leaving the model now; otherwise the word captured last cycle.
      if (RD_LATENCY == 0) begin
         cmp_vld_s = rd_acc_s;
         cmp_exp_s = mem_r[rd_ptr_r];
      end else begin
         cmp_vld_s = pend_vld_r && ((state_r == ST_RUN) || (state_r == ST_FLUSH));
         cmp_exp_s = pend_data_r;
      end
      cmp_ok_s  = cmp_vld_s && (rd_data == cmp_exp_s);
      cmp_bad_s = cmp_vld_s && (rd_data != cmp_exp_s);

      case ({wr_acc_s, rd_acc_s})
         2'b10:   occ_s = occ_r + (AW+1)'(1);
         2'b01:   occ_s = occ_r - (AW+1)'(1);
         default: occ_s = occ_r;
      endcase

      match_s = sat_inc(match_cnt_r, cmp_ok_s);
      error_s = error_r || cmp_bad_s || flag_bad_s;
      pass_s  = (state_s == ST_DONE) && !error_s && (match_s != '0) && (occ_s == '0);
   end

   // Shadow storage; contents are only meaningful below the occupancy, so no reset is needed.
   always_ff @(posedge clk) begin
      if (wr_acc_s) begin
         mem_r[wr_ptr_r] <= wr_data;
      end else begin
         mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
      end
   end

   // Model pointers, pending-compare pipeline, counters and verdict.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_r        <= ST_IDLE;
         occ_r          <= '0;
         wr_ptr_r       <= '0;
         rd_ptr_r       <= '0;
         pend_vld_r     <= 1'b0;
         pend_data_r    <= '0;
         match_cnt_r    <= '0;
         mismatch_cnt_r <= '0;
         flag_err_cnt_r <= '0;
         error_r        <= 1'b0;
         done_r         <= 1'b0;
         pass_r         <= 1'b0;
      end else begin
         state_r        <= state_s;
         occ_r          <= occ_s;
         wr_ptr_r       <= wr_acc_s ? wr_ptr_r + AW'(1) : wr_ptr_r;
         rd_ptr_r       <= rd_acc_s ? rd_ptr_r + AW'(1) : rd_ptr_r;
         pend_vld_r     <= (RD_LATENCY != 0) && rd_acc_s;
         pend_data_r    <= rd_acc_s ? mem_r[rd_ptr_r] : pend_data_r;
         match_cnt_r    <= match_s;
         mismatch_cnt_r <= sat_inc(mismatch_cnt_r, cmp_bad_s);
         flag_err_cnt_r <= sat_inc(flag_err_cnt_r, flag_bad_s);
         error_r        <= error_s;
         done_r         <= (state_s == ST_DONE);
         pass_r         <= pass_s;
      end
   end

   assign match_cnt    = match_cnt_r;
   assign mismatch_cnt = mismatch_cnt_r;
   assign flag_err_cnt = flag_err_cnt_r;
   assign error        = error_r;
   assign done         = done_r;
   assign pass         = pass_r;

endmodule

// File: tb/tb_fifo_scoreboard_chk.sv
// Bench for fifo_scoreboard_chk: plays the part of a DEPTH=4 FIFO DUT (with injectable faults)
// and predicts the scoreboard outputs from a queue-based reference model.
module tb_fifo_scoreboard_chk;

   localparam int PH_IDLE  = 0;
   localparam int PH_RUN   = 1;
   localparam int PH_FLUSH = 2;
   localparam int PH_DONE  = 3;
   localparam int DEPTH    = 4;

   logic        clk = 1'b0;
   logic        rstn;
   logic        wr_en;
   logic [7:0]  wr_data;
   logic        rd_en;
   logic [7:0]  rd_data;
   logic        full;
   logic        empty;
   logic        test_done;
   logic [15:0] match_cnt;
   logic [15:0] mismatch_cnt;
   logic [15:0] flag_err_cnt;
   logic        error;
   logic        done;
   logic        pass;

   int checks = 0;
   int errors = 0;

   logic [7:0] ref_q[$];
   logic [7:0] fifo_q[$];
   int         phase;
   int         exp_match;
   int         exp_mis;
   int         exp_flag;
   bit         exp_err;
   bit         pend;
   logic [7:0] pend_data;

   always #5 clk = ~clk;

   fifo_scoreboard_chk #(.DW(8), .DEPTH(DEPTH), .RD_LATENCY(1), .CNT_W(16)) dut (
      .clk(clk), .rstn(rstn), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
      .rd_data(rd_data), .full(full), .empty(empty), .test_done(test_done),
      .match_cnt(match_cnt), .mismatch_cnt(mismatch_cnt), .flag_err_cnt(flag_err_cnt),
      .error(error), .done(done), .pass(pass)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_all();
      chk("match_cnt", 32'(match_cnt), 32'(exp_match));
      chk("mismatch_cnt", 32'(mismatch_cnt), 32'(exp_mis));
      chk("flag_err_cnt", 32'(flag_err_cnt), 32'(exp_flag));
      chk("error", 32'(error), 32'(exp_err));
      chk("done", 32'(done), 32'(phase == PH_DONE));
      chk("pass", 32'(pass),
          32'((phase == PH_DONE) && !exp_err && (exp_match != 0) && (ref_q.size() == 0)));
   endtask

   task automatic model_compare();
      if (pend) begin
         if (rd_data === pend_data) exp_match++;
         else begin
            exp_mis++;
            exp_err = 1'b1;
         end
         pend = 1'b0;
      end
   endtask

   // One clock: flip bit0 corrupts empty, bit1 corrupts full; mask corrupts the returned word.
   task automatic cyc(input bit wr, input logic [7:0] wd, input bit rd, input bit td,
                      input logic [1:0] flip, input logic [7:0] mask);
      int         occ;
      bit         dut_rd;
      bit         dut_wr;
      logic [7:0] popped;
      popped    = 8'h00;
      wr_en     = wr;
      wr_data   = wd;
      rd_en     = rd;
      test_done = td;
      full      = (fifo_q.size() == DEPTH) ^ flip[1];
      empty     = (fifo_q.size() == 0) ^ flip[0];
      case (phase)
         PH_IDLE: phase = PH_RUN;
         PH_RUN: begin
            occ = ref_q.size();
            if ((empty != (occ == 0)) || (full != (occ == DEPTH))) begin
               exp_flag++;
               exp_err = 1'b1;
            end
            model_compare();
            if (rd && occ > 0) begin
               pend      = 1'b1;
               pend_data = ref_q.pop_front();
            end
            if (wr && occ < DEPTH) ref_q.push_back(wd);
            if (td) phase = PH_FLUSH;
         end
         PH_FLUSH: begin
            model_compare();
            phase = PH_DONE;
         end
         default: ;
      endcase
      dut_rd = rd && (fifo_q.size() > 0);
      dut_wr = wr && (fifo_q.size() < DEPTH);
      if (dut_rd) popped = fifo_q.pop_front();
      if (dut_wr) fifo_q.push_back(wd);
      @(posedge clk);
      #1;
      if (dut_rd) rd_data = popped ^ mask;
      wr_en     = 1'b0;
      rd_en     = 1'b0;
      test_done = 1'b0;
      check_all();
   endtask

   task automatic do_reset();
      rstn      = 1'b0;
      wr_en     = 1'b0;
      rd_en     = 1'b0;
      test_done = 1'b0;
      @(posedge clk);
      #1;
      rstn      = 1'b1;
      ref_q.delete();
      fifo_q.delete();
      phase     = PH_IDLE;
      exp_match = 0;
      exp_mis   = 0;
      exp_flag  = 0;
      exp_err   = 1'b0;
      pend      = 1'b0;
      rd_data   = 8'h00;
      full      = 1'b0;
      empty     = 1'b1;
      check_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 8'h00);
   endtask

   initial begin
      rstn = 1'b0; wr_en = 1'b0; wr_data = 8'h00; rd_en = 1'b0; rd_data = 8'h00;
      full = 1'b0; empty = 1'b1; test_done = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Basic: three writes, three reads, last read coincides with test_done
      do_reset();
      idle(1);
      cyc(1'b1, 8'h11, 1'b0, 1'b0, 2'b00, 8'h00);
      cyc(1'b1, 8'h22, 1'b0, 1'b0, 2'b00, 8'h00);
      cyc(1'b1, 8'h33, 1'b0, 1'b0, 2'b00, 8'h00);
      cyc(1'b0, 8'h00, 1'b1, 1'b0, 2'b00, 8'h00);
      cyc(1'b0, 8'h00, 1'b1, 1'b0, 2'b00, 8'h00);
      cyc(1'b0, 8'h00, 1'b1, 1'b1, 2'b00, 8'h00);
      chk("A_done_early", 32'(done), 32'd0);
      idle(1);
      chk("A_match", 32'(match_cnt), 32'd3);
      chk("A_done", 32'(done), 32'd1);
      chk("A_pass", 32'(pass), 32'd1);
      // Inputs after DONE must not move anything
      cyc(1'b1, 8'h99, 1'b1, 1'b0, 2'b11, 8'hFF);
      cyc(1'b0, 8'h00, 1'b1, 1'b1, 2'b01, 8'h00);
      chk("A_frozen", 32'(match_cnt), 32'd3);

      // Overflow drop, full-boundary and empty-boundary simultaneous access
      do_reset();
      idle(1);
      for (int i = 0; i < 5; i++) cyc(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0, 2'b00, 8'h00);
      cyc(1'b1, 8'hEE, 1'b1, 1'b0, 2'b00, 8'h00);
      for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0, 2'b00, 8'h00);
      cyc(1'b1, 8'h77, 1'b1, 1'b0, 2'b00, 8'h00);
      cyc(1'b0, 8'h00, 1'b1, 1'b0, 2'b00, 8'h00);
      cyc(1'b0, 8'h00, 1'b0, 1'b1, 2'b00, 8'h00);
      idle(1);
      chk("B_match", 32'(match_cnt), 32'd5);
      chk("B_error", 32'(error), 32'd0);
      chk("B_pass", 32'(pass), 32'd1);

      // Data mismatch: second read returns 0x23 instead of 0x22
      do_reset();
      idle(1);
      cyc(1'b1, 8'h11, 1'b0, 1'b0, 2'b00, 8'h00);
      cyc(1'b1, 8'h22, 1'b0, 1'b0, 2'b00, 8'h00);
      cyc(1'b1, 8'h33, 1'b0, 1'b0, 2'b00, 8'h00);
      cyc(1'b0, 8'h00, 1'b1, 1'b0, 2'b00, 8'h00);
      cyc(1'b0, 8'h00, 1'b1, 1'b0, 2'b00, 8'h01);
      chk("C_error_pre", 32'(error), 32'd0);
      cyc(1'b0, 8'h00, 1'b1, 1'b0, 2'b00, 8'h00);
      chk("C_error_post", 32'(error), 32'd1);
      cyc(1'b0, 8'h00, 1'b0, 1'b1, 2'b00, 8'h00);
      idle(1);
      chk("C_mismatch", 32'(mismatch_cnt), 32'd1);
      chk("C_pass", 32'(pass), 32'd0);

      // Empty flag wrongly low for two checked cycles
      do_reset();
      idle(1);
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 2'b01, 8'h00);
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 2'b01, 8'h00);
      chk("D_flag_err", 32'(flag_err_cnt), 32'd2);
      chk("D_error", 32'(error), 32'd1);

      // Reset mid-run discards history
      do_reset();
      idle(1);
      for (int i = 0; i < 3; i++) cyc(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0, 2'b00, 8'h00);
      do_reset();
      idle(1);
      cyc(1'b1, 8'h55, 1'b0, 1'b0, 2'b00, 8'h00);
      cyc(1'b0, 8'h00, 1'b1, 1'b0, 2'b00, 8'h00);
      cyc(1'b0, 8'h00, 1'b0, 1'b1, 2'b00, 8'h00);
      idle(1);
      chk("E_match", 32'(match_cnt), 32'd1);
      chk("E_pass", 32'(pass), 32'd1);

      // Randomised traffic with occasional flag and data corruption
      do_reset();
      idle(1);
      for (int i = 0; i < 300; i++) begin
         cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0,
             ($urandom_range(0, 31) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
             ($urandom_range(0, 15) == 0) ? 8'h40 : 8'h00);
      end
      cyc(1'b0, 8'h00, 1'b1, 1'b1, 2'b00, 8'h00);
      idle(2);
      chk("R_done", 32'(done), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
